// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one outstanding word read at a time and holds
// the returned instruction in a single-entry slot for the IF/ID register.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] slot_pc, slot_pc_n;
   logic [31:0] slot_inst, slot_inst_n;
   logic        slot_valid, slot_valid_n;
   logic        mem_req_n;
   logic [31:0] mem_addr_n;
   logic        consume;

   // Only the fetch-stage hold bit and the word-aligned target bits matter here.
   logic unused_inputs;
   assign unused_inputs = ^{stall[5:1], branch_target[1:0]};

   assign consume = !stall[0] && slot_valid && !branch_flag;

   assign if_pc   = slot_pc;
   assign if_inst = slot_valid ? slot_inst : NOP_INST;

   always_comb begin
      state_n      = state;
      fetch_pc_n   = fetch_pc;
      slot_pc_n    = slot_pc;
      slot_inst_n  = slot_inst;
      slot_valid_n = slot_valid;
      mem_req_n    = mem_req;
      mem_addr_n   = mem_addr;

      if (branch_flag) begin
         slot_valid_n = 1'b0;
         fetch_pc_n   = {branch_target[31:2], 2'b00};
      end else if (consume) begin
         slot_valid_n = 1'b0;
      end

      unique case (state)
         S_IDLE: begin
            if ((!slot_valid || consume) && !branch_flag) begin
               mem_req_n  = 1'b1;
               mem_addr_n = fetch_pc;
               state_n    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               mem_req_n = 1'b0;
               state_n   = S_IDLE;
               if (!branch_flag) begin
                  slot_inst_n  = mem_rdata;
                  slot_pc_n    = mem_addr;
                  slot_valid_n = 1'b1;
                  fetch_pc_n   = mem_addr + 32'd4;
               end
            end else if (branch_flag) begin
               state_n = S_DROP;
            end
         end
         S_DROP: begin
            if (mem_ack) begin
               mem_req_n = 1'b0;
               state_n   = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         fetch_pc   <= RESET_PC;
         slot_pc    <= '0;
         slot_inst  <= NOP_INST;
         slot_valid <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
      end else begin
         state      <= state_n;
         fetch_pc   <= fetch_pc_n;
         slot_pc    <= slot_pc_n;
         slot_inst  <= slot_inst_n;
         slot_valid <= slot_valid_n;
         mem_req    <= mem_req_n;
         mem_addr   <= mem_addr_n;
      end
   end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, fetch address loaded on reset.
REQ-002 Parameter NOP_INST, 32'h00000013, instruction presented when no fetched word is held (addi x0,x0,0).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  6  pipeline hold vector from ctrl; bit 0 = fetch-stage hold, 1 = hold.
REQ-006 branch_flag  input  1  single-cycle redirect pulse from EX.
REQ-007 branch_target  input  32  redirect address, valid when branch_flag=1.
REQ-008 mem_req  output  1  instruction read request to memory controller (registered).
REQ-009 mem_addr  output  32  word address of request (registered).
REQ-010 mem_ack  input  1  single-cycle read completion; mem_rdata valid same cycle.
REQ-011 mem_rdata  input  32  instruction word returned.
REQ-012 if_pc  output  32  PC of presented instruction, to IF/ID register.
REQ-013 if_inst  output  32  presented instruction, to IF/ID register.

Function
REQ-014 Internal state: fetch_pc (32b), slot_pc/slot_inst (32b each), slot_valid (1b), FSM {S_IDLE, S_WAIT, S_DROP}.
REQ-015 if_pc SHALL equal slot_pc and if_inst slot_inst when slot_valid=1; otherwise if_pc=slot_pc, if_inst=NOP_INST (combinational from registers).
REQ-016 At most one memory request outstanding; mem_req high only in S_WAIT and S_DROP.
REQ-017 mem_req and mem_addr SHALL stay stable from assertion through the edge at which mem_ack=1 is sampled; request never withdrawn early.
REQ-018 Consume event: edge with stall[0]=0, slot_valid=1, branch_flag=0 -> slot_valid<=0.
REQ-019 S_IDLE: if (slot_valid=0 or consume) and branch_flag=0 -> mem_req<=1, mem_addr<=fetch_pc, go S_WAIT; else stay.
REQ-020 S_WAIT, mem_ack=1, branch_flag=0: slot_inst<=mem_rdata, slot_pc<=mem_addr, slot_valid<=1, fetch_pc<=mem_addr+4, mem_req<=0, go S_IDLE.
REQ-021 S_WAIT, mem_ack=0: hold all state.
REQ-022 Branch (branch_flag=1) in any state: slot_valid<=0, fetch_pc<={branch_target[31:2],2'b00}; priority over stall[0] and over consume.
REQ-023 Branch in S_WAIT with mem_ack=0 -> S_DROP; branch in S_WAIT with mem_ack=1 -> returned data discarded, mem_req<=0, S_IDLE.
REQ-024 S_DROP: on mem_ack=1 discard data, mem_req<=0, go S_IDLE; further branches only update fetch_pc.
REQ-025 mem_ack in S_IDLE SHALL be ignored.
REQ-026 fetch_pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-027 Latency: ack at edge t -> instruction on if_inst after t; earliest next mem_req assertion after edge t+1 (consume at t+1).
REQ-028 stall[0]=1 holds slot contents and suppresses new issue while slot_valid=1; outstanding request still completes into empty slot.

Reset
REQ-029 rst=1 at edge: fetch_pc<=RESET_PC, slot_pc<=32'h0, slot_inst<=NOP_INST, slot_valid<=0, mem_req<=0, mem_addr<=32'h0, state S_IDLE; overrides branch, ack, stall.
REQ-030 Reset mid-request abandons it; a late mem_ack after reset is ignored (S_IDLE rule).
REQ-031 First mem_req after reset release: asserted after first edge with rst=0, mem_addr=RESET_PC.

Verification
REQ-032 Reset release, ack 2 cycles after each req, stall=0 -> mem_addr 0x0,0x4,0x8 in order; if_pc/if_inst match memory; NOP_INST between words.
REQ-033 stall[0]=1 for 5 cycles with slot_valid=1 -> if_pc/if_inst unchanged, mem_req stays 0; release -> next req at slot_pc+4.
REQ-034 branch_flag with target 0x103 while S_WAIT, ack 3 cycles later -> ack data never presented; next mem_addr=0x100.
REQ-035 branch_flag same cycle as mem_ack -> data discarded, next mem_addr=target; branch same cycle as stall[0]=1 -> slot flushed to NOP_INST.
REQ-036 fetch_pc=0xFFFFFFFC, ack -> next mem_addr=0x00000000; rst mid S_WAIT then ack -> ignored, mem_addr=RESET_PC.
